// File: rtl/mem_port_arbiter.sv
// Shared single-port memory sequencer for fetch (read-only) and data (read/write).
// Data side wins unless a pending fetch has been passed over MAX_STARVE times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = 4;
    localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;

    assign grant_dm = dm_req && !(if_req && (starve_q == SW'(MAX_STARVE)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    owner_d = 1'b1;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    wait_d  = CW'(LATENCY - 1);
                    state_d = BUSY;
                    // Only a passed-over fetch counts toward starvation
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != SW'(MAX_STARVE))
                        starve_d = starve_q + 1'b1;
                end else if (if_req) begin
                    owner_d  = 1'b0;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    wait_d   = CW'(LATENCY - 1);
                    state_d  = BUSY;
                    starve_d = '0;
                end
            end
            BUSY: begin
                if (wait_q == '0) begin
                    state_d = DONE;
                    if (owner_q)
                        dm_rdata_d = we_q ? '0 : mem_rdata;
                    else
                        if_rdata_d = mem_rdata;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state_q == DONE) && !owner_q;
    assign dm_ready  = (state_q == DONE) && owner_q;
    assign if_stall  = if_req && !if_ready;
    assign dm_stall  = dm_req && !dm_ready;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-latency memory device plus
// transaction-level ordering and data model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MS  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic        mem_load;
    int unsigned busy_n;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .MAX_STARVE(MS)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ready(dm_ready), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory device: data is only valid at the LATENCY-th edge of an access
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
            busy_n <= 0;
        end else if (mem_req) begin
            busy_n <= busy_n + 1;
            if (mem_we && busy_n == 0) mem[mem_addr[7:0]] <= mem_wdata;
        end else begin
            busy_n <= 0;
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0_0000 | busy_n;
        if (mem_req && busy_n == LAT - 1) mem_rdata = mem[mem_addr[7:0]];
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({mem_req, mem_we, if_ready, dm_ready} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {mem_req, mem_we, if_ready, dm_ready}); end
        checks++; if ({mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata}); end
        checks++; if ({if_rdata, dm_rdata} !== '0) begin
            errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, dm_rdata}); end
        checks++; if ({if_stall, dm_stall} !== 2'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 00", {if_stall, dm_stall}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, if_ready, dm_ready} !== 3'b0) begin
            errors++; $display("FAIL idle_after_reset got %b exp 000", {mem_req, if_ready, dm_ready}); end
    endtask

    task automatic test_single_fetch();
        logic exp_req, exp_rdy;
        if_req = 1'b1; if_addr = 32'h4;
        #1;
        checks++; if (if_stall !== 1'b1) begin
            errors++; $display("FAIL fetch_stall_req got %b exp 1", if_stall); end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            exp_req = (k <= LAT);
            exp_rdy = (k == LAT + 1);
            checks++; if (mem_req !== exp_req) begin
                errors++; $display("FAIL fetch_mem_req k=%0d got %b exp %b", k, mem_req, exp_req); end
            checks++; if (if_ready !== exp_rdy || dm_ready !== 1'b0) begin
                errors++; $display("FAIL fetch_ready k=%0d got %b%b exp %b0", k, if_ready, dm_ready, exp_rdy); end
            checks++; if (if_stall !== !exp_rdy) begin
                errors++; $display("FAIL fetch_stall k=%0d got %b exp %b", k, if_stall, !exp_rdy); end
            if (exp_req) begin
                checks++; if (mem_addr !== 32'h4 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL fetch_bus k=%0d got addr %h we %b exp 4 0", k, mem_addr, mem_we); end
            end
            if (k == 1) if_addr = 32'h3C;
        end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata); end
        if_req = 1'b0; if_addr = '0;
        @(negedge clk);
        checks++; if ({mem_req, if_ready} !== 2'b0) begin
            errors++; $display("FAIL fetch_after got %b exp 00", {mem_req, if_ready}); end
    endtask

    task automatic test_data_write();
        logic exp_req, exp_rdy;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'h12345678;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            exp_req = (k <= LAT);
            exp_rdy = (k == LAT + 1);
            checks++; if (mem_req !== exp_req || mem_we !== exp_req) begin
                errors++; $display("FAIL wr_strobe k=%0d got %b%b exp %b%b", k, mem_req, mem_we, exp_req, exp_req); end
            if (exp_req) begin
                checks++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h10) begin
                    errors++; $display("FAIL wr_bus k=%0d got %h@%h exp 12345678@10", k, mem_wdata, mem_addr); end
            end
            checks++; if (dm_ready !== exp_rdy || if_ready !== 1'b0) begin
                errors++; $display("FAIL wr_ready k=%0d got %b%b exp %b0", k, dm_ready, if_ready, exp_rdy); end
            checks++; if (dm_stall !== !exp_rdy) begin
                errors++; $display("FAIL wr_stall k=%0d got %b exp %b", k, dm_stall, !exp_rdy); end
            if (k == 1) dm_wdata = 32'hFFFF0000;
        end
        checks++; if (dm_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rdata got %h exp 0", dm_rdata); end
        ref_mem[8'h10] = 32'h12345678;
        dm_req = 1'b0; dm_we = 1'b0;
        #1;
        checks++; if (dm_stall !== 1'b0) begin
            errors++; $display("FAIL wr_stall_idle got %b exp 0", dm_stall); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        logic exp_req;
        logic [31:0] exp_addr;
        if_req = 1'b1; if_addr = 32'h8;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int k = 1; k <= 2 * LAT + 3; k++) begin
            @(negedge clk);
            exp_req = (k <= LAT) || (k >= LAT + 3 && k <= 2 * LAT + 2);
            exp_addr = (k <= LAT) ? 32'h20 : 32'h8;
            checks++; if (mem_req !== exp_req) begin
                errors++; $display("FAIL sim_mem_req k=%0d got %b exp %b", k, mem_req, exp_req); end
            if (exp_req) begin
                checks++; if (mem_addr !== exp_addr) begin
                    errors++; $display("FAIL sim_addr k=%0d got %h exp %h", k, mem_addr, exp_addr); end
            end
            checks++; if (dm_ready !== (k == LAT + 1) || if_ready !== (k == 2 * LAT + 3)) begin
                errors++; $display("FAIL sim_ready k=%0d got if%b dm%b", k, if_ready, dm_ready); end
            if (k == LAT + 1) begin
                checks++; if (dm_rdata !== ref_mem[8'h20]) begin
                    errors++; $display("FAIL sim_dm_rdata got %h exp %h", dm_rdata, ref_mem[8'h20]); end
                dm_req = 1'b0;
            end
        end
        checks++; if (if_rdata !== ref_mem[8'h08]) begin
            errors++; $display("FAIL sim_if_rdata got %h exp %h", if_rdata, ref_mem[8'h08]); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int k = 0;
        int got = 0;
        int last = 0;
        bit exp_dm;
        if_req = 1'b1; if_addr = 32'h30;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        while (got < 8 && k < 8 * (LAT + 2) + 10) begin
            @(negedge clk); k++;
            if (if_ready || dm_ready) begin
                exp_dm = (got % (MS + 1)) != MS;
                checks++; if ({dm_ready, if_ready} !== {exp_dm, !exp_dm}) begin
                    errors++; $display("FAIL starve_owner n=%0d got dm%b if%b exp dm%b", got, dm_ready, if_ready, exp_dm); end
                checks++; if (k - last != ((got == 0) ? LAT + 1 : LAT + 2)) begin
                    errors++; $display("FAIL starve_spacing n=%0d got %0d", got, k - last); end
                if (exp_dm) begin
                    checks++; if (dm_rdata !== ref_mem[8'h40]) begin
                        errors++; $display("FAIL starve_dm_rdata got %h exp %h", dm_rdata, ref_mem[8'h40]); end
                end else begin
                    checks++; if (if_rdata !== ref_mem[8'h30]) begin
                        errors++; $display("FAIL starve_if_rdata got %h exp %h", if_rdata, ref_mem[8'h30]); end
                end
                last = k; got++;
            end
        end
        checks++; if (got != 8) begin
            errors++; $display("FAIL starve_timeout got %0d pulses exp 8", got); end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int kr;
        kr = (LAT >= 2) ? 2 : 1;
        if_req = 1'b1; if_addr = 32'h50;
        for (int k = 1; k <= kr; k++) @(negedge clk);
        reset = 1'b1; if_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, mem_we, if_ready, dm_ready} !== 4'b0) begin
            errors++; $display("FAIL rstmid_ctrl got %b exp 0000", {mem_req, mem_we, if_ready, dm_ready}); end
        checks++; if ({if_rdata, dm_rdata} !== '0) begin
            errors++; $display("FAIL rstmid_rdata got %h exp 0", {if_rdata, dm_rdata}); end
        reset = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            checks++; if ({mem_req, if_ready, dm_ready} !== 3'b0) begin
                errors++; $display("FAIL rstmid_quiet k=%0d got %b exp 000", k, {mem_req, if_ready, dm_ready}); end
        end
    endtask

    task automatic test_back_to_back_random();
        int starve = 0;
        int k, got, n;
        bit wi, wd, we;
        logic [7:0] ia, da;
        logic [31:0] wdat;
        bit own [2];
        int ek [2];
        logic [31:0] ed [2];
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0: begin wi = 1'b1; wd = 1'b0; end
                1: begin wi = 1'b0; wd = 1'b1; end
                default: begin wi = 1'b1; wd = 1'b1; end
            endcase
            ia = 8'($urandom_range(0, 255));
            da = 8'($urandom_range(0, 255));
            we = 1'($urandom_range(0, 1));
            wdat = $urandom;
            // Grant order from the priority/starvation rule
            if (wd && !(wi && starve == MS)) begin
                own[0] = 1'b1; n = 1;
                starve = wi ? ((starve == MS) ? MS : starve + 1) : 0;
                if (wi) begin own[1] = 1'b0; n = 2; starve = 0; end
            end else begin
                own[0] = 1'b0; n = 1; starve = 0;
                if (wd) begin own[1] = 1'b1; n = 2; starve = 0; end
            end
            for (int j = 0; j < n; j++) begin
                ek[j] = (j == 0) ? LAT + 1 : 2 * LAT + 3;
                if (!own[j]) ed[j] = ref_mem[ia];
                else if (we) begin ed[j] = '0; ref_mem[da] = wdat; end
                else ed[j] = ref_mem[da];
            end
            if_req = wi; if_addr = {24'b0, ia};
            dm_req = wd; dm_we = we; dm_addr = {24'b0, da}; dm_wdata = wdat;
            k = 0; got = 0;
            while (got < n && k < 2 * LAT + 8) begin
                @(negedge clk); k++;
                if (if_ready || dm_ready) begin
                    checks++; if ({if_ready, dm_ready} !== (own[got] ? 2'b01 : 2'b10)) begin
                        errors++; $display("FAIL rnd_owner r=%0d got if%b dm%b exp dm=%b", r, if_ready, dm_ready, own[got]); end
                    checks++; if (k != ek[got]) begin
                        errors++; $display("FAIL rnd_latency r=%0d got %0d exp %0d", r, k, ek[got]); end
                    if (own[got]) begin
                        checks++; if (dm_rdata !== ed[got]) begin
                            errors++; $display("FAIL rnd_dm_rdata r=%0d got %h exp %h", r, dm_rdata, ed[got]); end
                        dm_req = 1'b0;
                    end else begin
                        checks++; if (if_rdata !== ed[got]) begin
                            errors++; $display("FAIL rnd_if_rdata r=%0d got %h exp %h", r, if_rdata, ed[got]); end
                        if_req = 1'b0;
                    end
                    got++;
                end
            end
            checks++; if (got != n) begin
                errors++; $display("FAIL rnd_timeout r=%0d got %0d pulses exp %0d", r, got, n); end
            if_req = 1'b0; dm_req = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'hDEADBEEF;
        mem_load = 1'b1;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_load = 1'b0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
